deser_8bit_align: RTL and testbench
===================================

# deser_8bit_align

Serial-to-parallel front end of the receive path. It shifts in a 1-bit serial stream, hunts for a sync byte to establish word alignment, and emits aligned 8-bit payload words with a one-cycle `data_en` strobe. Its `data_8b_out` and `data_en` outputs drive the 8-bit output latch directly.

## Interface

Parameters:
- `SYNC_WORD`, default 8'hBC: alignment byte, transmitted MSB first. Must be non-zero.
- `FRAME_LEN`, default 16: words per frame, including the sync word. Minimum 2.
- `MISS_LIMIT`, default 3: number of consecutive bad sync words that causes loss of lock. Used only with the macro.

Ports:
- `clk` input 1: the single clock. All logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ser_in` input 1: serial data, MSB first, one bit per cycle.
- `align_en` input 1: enables hunting and holding lock. Low forces HUNT.
- `data_8b_out` output 8: last aligned payload word.
- `data_en` output 1: one-cycle strobe, high when `data_8b_out` holds a new word.
- `locked` output 1: high while the state is LOCKED.
- `sync_err` output 1: one-cycle pulse when a sync-position word mismatches. Tied to 0 without the macro.

## Operation

- Shift register `sr[7:0]`: every cycle `sr <= sh`, where `sh = {sr[6:0], ser_in}`.
- State HUNT:
  - If `align_en && sh == SYNC_WORD`, go to LOCKED with `bit_cnt <= 0` and `word_cnt <= 1`.
  - Otherwise stay in HUNT with the counters held at 0.
- State LOCKED:
  - `bit_cnt` increments every cycle, 0..7, and wraps.
  - When `bit_cnt == 7` the word is complete and equals `sh`.
  - If `word_cnt != 0`: `data_8b_out <= sh` and `data_en <= 1`.
  - If `word_cnt == 0` (sync position): the word is never output and `data_8b_out` holds its value.
  - `word_cnt` increments at each word completion and wraps from FRAME_LEN-1 to 0.
- `align_en` low in any state: next edge goes to HUNT and clears `bit_cnt`, `word_cnt` and the miss counter. `data_8b_out` holds its value.
- `data_en` is low on every cycle without a completed payload word.
- The shift register keeps shifting in all states.

## Timing

- Reset values:
  - `sr`, `data_8b_out`: 0.
  - `data_en`, `locked`, `sync_err`: 0.
  - State: HUNT. All counters: 0.
- Lock latency: the last sync bit is sampled at edge t, and `locked` is high from edge t.
- The first payload bit is sampled at edge t+1.
- Word latency: the 8th bit of a word is sampled at edge t, and `data_8b_out` and `data_en` are valid from edge t until edge t+1. This is one registered stage.
- `data_en` strobes are spaced 8 cycles apart. There is a 16-cycle gap across the sync position.
- Reset asserted mid-word: all outputs go to their reset values immediately. A partial word is discarded.
- `align_en` falling on the same edge as a word completion: HUNT takes priority and no `data_en` is issued.

## Configuration

- Macro `DESER_LOSS_DET_EN`.
- Defined:
  - At each sync-position completion, compare `sh` with SYNC_WORD.
  - On mismatch: pulse `sync_err` for one cycle and increment the miss counter.
  - On match: clear the miss counter.
  - When the miss counter reaches MISS_LIMIT: go to HUNT on that same edge and clear the counter.
- Undefined:
  - The sync-position word is dropped without comparison.
  - Lock is lost only through `align_en` or reset.
  - `sync_err` is constant 0.

## Test plan

- Lock and first word: reset, then drive 8'hBC followed by 8'hA5 MSB first. Expect `locked` high on the edge sampling the 8th sync bit. Expect a `data_en` pulse with `data_8b_out == 8'hA5` on the edge sampling the 8th payload bit.
- Arbitrary alignment: 3 junk bits (1,0,1), then 8'hBC, then 8'h3C, 8'hC3. Expect exactly two strobes, carrying 8'h3C and 8'hC3, with no false lock during the junk bits.
- Full frame with FRAME_LEN=16: send two frames with payloads 8'h01..8'h0F. Expect 30 strobes in order, the sync byte never output, and the gap across the sync position.
- Loss detection (macro on, MISS_LIMIT=3):
  - Corrupt the sync to 8'hBD for 3 consecutive frames. Expect 3 `sync_err` pulses and `locked` falling on the third.
  - 2 bad frames then 1 good frame: `locked` stays high.
- Abort:
  - Deassert `align_en` at bit 4 of a payload word. Expect `locked == 0` next edge and no `data_en`. `data_8b_out` keeps its previous value.
  - Separately, assert `rst_n` low mid-word. Expect all outputs at 0 immediately.

Source files
------------

// File: rtl/deser_8bit_align.sv
// Serial-to-parallel receive front end with sync-byte word alignment.
// Define DESER_LOSS_DET_EN to enable sync-loss detection and sync_err.
module deser_8bit_align #(
  parameter logic [7:0] SYNC_WORD  = 8'hBC,
  parameter int         FRAME_LEN  = 16,
  parameter int         MISS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       align_en,
  output logic [7:0] data_8b_out,
  output logic       data_en,
  output logic       locked,
  output logic       sync_err
);

  localparam int WCW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(FRAME_LEN - 1);

  if (FRAME_LEN < 2 || SYNC_WORD == 8'h00 || MISS_LIMIT < 1)
  begin : g_bad_param
    $error("deser_8bit_align: illegal parameter value");
  end

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  state_e         state_q, state_d;
  // Only the low 7 bits are ever needed to form the next window.
  logic [6:0]     sr_q, sr_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           data_en_q, data_en_d;
  logic [7:0]     sh;

`ifdef DESER_LOSS_DET_EN
  localparam int MSW = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;
  localparam logic [MSW-1:0] MISS_LAST = MSW'(MISS_LIMIT - 1);

  logic [MSW-1:0] miss_q, miss_d;
  logic           sync_err_q, sync_err_d;
`endif

  always_comb begin
    sh         = {sr_q, ser_in};
    sr_d       = sh[6:0];
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    data_d     = data_q;
    data_en_d  = 1'b0;
`ifdef DESER_LOSS_DET_EN
    miss_d     = miss_q;
    sync_err_d = 1'b0;
`endif
    if (!align_en) begin
      state_d    = HUNT;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
`ifdef DESER_LOSS_DET_EN
      miss_d     = '0;
`endif
    end else begin
      unique case (state_q)
        HUNT: begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          if (sh == SYNC_WORD) begin
            state_d    = LOCKED;
            word_cnt_d = WCW'(1);
          end
        end
        LOCKED: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            word_cnt_d = (word_cnt_q == WC_LAST) ? '0
                       : word_cnt_q + WCW'(1);
            if (word_cnt_q != '0) begin
              data_d    = sh;
              data_en_d = 1'b1;
            end
`ifdef DESER_LOSS_DET_EN
            else if (sh != SYNC_WORD) begin
              sync_err_d = 1'b1;
              if (miss_q == MISS_LAST) begin
                state_d    = HUNT;
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                miss_d     = '0;
              end else begin
                miss_d = miss_q + MSW'(1);
              end
            end else begin
              miss_d = '0;
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      data_q     <= '0;
      data_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      data_q     <= data_d;
      data_en_q  <= data_en_d;
    end
  end

`ifdef DESER_LOSS_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      miss_q     <= miss_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

  assign data_8b_out = data_q;
  assign data_en     = data_en_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_deser_8bit_align.sv
// Scoreboard bench for deser_8bit_align (default parameters).
// Covers both builds; loss expectations follow DESER_LOSS_DET_EN.
module tb_deser_8bit_align;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_in;
  logic       align_en;
  logic [7:0] data_8b_out;
  logic       data_en;
  logic       locked;
  logic       sync_err;

`ifdef DESER_LOSS_DET_EN
  localparam bit LOSS = 1'b1;
`else
  localparam bit LOSS = 1'b0;
`endif

  always #5 clk = ~clk;

  deser_8bit_align dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_in      (ser_in),
    .align_en    (align_en),
    .data_8b_out (data_8b_out),
    .data_en     (data_en),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] sb[$];
  logic [7:0] mon_exp;
  int         strobe_cnt, serr_cnt;
  int         gap8, gap16, gap_other;
  int         cyc = 0;
  int         last_strobe;

  always @(posedge clk) cyc++;

  // Scoreboard: every strobe must match the oldest pending payload.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (sync_err === 1'b1) serr_cnt++;
      if (data_en === 1'b1) begin
        strobe_cnt++;
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL strobe_unexpected: got %h required none",
                   data_8b_out);
        end else begin
          mon_exp = sb.pop_front();
          if (data_8b_out !== mon_exp)
            $display("FAIL strobe_data: got %h required %h",
                     data_8b_out, mon_exp);
          else
            pass_cnt++;
        end
        if (last_strobe >= 0) begin
          if (cyc - last_strobe == 8) gap8++;
          else if (cyc - last_strobe == 16) gap16++;
          else gap_other++;
        end
        last_strobe = cyc;
      end
    end
  end

  task automatic clear_stats();
    sb.delete();
    strobe_cnt  = 0;
    serr_cnt    = 0;
    gap8        = 0;
    gap16       = 0;
    gap_other   = 0;
    last_strobe = -1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    align_en = 1'b0;
    ser_in   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ser_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push);
    if (push) sb.push_back(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_frame_payload();
    for (int p = 1; p < 16; p++) send_byte(8'(p), 1'b1);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    align_en = 1'b0;
    ser_in   = 1'b1;
    #3;
    total_cnt++;
    if (data_8b_out !== 8'h00)
      $display("FAIL rst_data: got %h required 00", data_8b_out);
    else pass_cnt++;
    total_cnt++;
    if (data_en !== 1'b0)
      $display("FAIL rst_data_en: got %b required 0", data_en);
    else pass_cnt++;
    total_cnt++;
    if (locked !== 1'b0)
      $display("FAIL rst_locked: got %b required 0", locked);
    else pass_cnt++;
    total_cnt++;
    if (sync_err !== 1'b0)
      $display("FAIL rst_sync_err: got %b required 0", sync_err);
    else pass_cnt++;
    do_reset();
    send_byte(8'hBC, 1'b0);
    total_cnt++;
    if (locked !== 1'b0)
      $display("FAIL lock_disabled: got %b required 0", locked);
    else pass_cnt++;
  endtask

  task automatic test_lock_first_word();
    logic [7:0] s;
    s = 8'hBC;
    do_reset();
    align_en = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(s[i]);
    total_cnt++;
    if (locked !== 1'b0)
      $display("FAIL lock_early: got %b required 0", locked);
    else pass_cnt++;
    send_bit(s[0]);
    total_cnt++;
    if (locked !== 1'b1)
      $display("FAIL lock_edge: got %b required 1", locked);
    else pass_cnt++;
    send_byte(8'hA5, 1'b1);
    total_cnt++;
    if (data_en !== 1'b1 || data_8b_out !== 8'hA5)
      $display("FAIL first_word: got en=%b %h required en=1 a5",
               data_en, data_8b_out);
    else pass_cnt++;
    send_bit(1'b0);
    total_cnt++;
    if (data_en !== 1'b0)
      $display("FAIL strobe_width: got %b required 0", data_en);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (strobe_cnt != 1 || sb.size() != 0)
      $display("FAIL first_count: got %0d/%0d required 1/0",
               strobe_cnt, sb.size());
    else pass_cnt++;
  endtask

  task automatic test_arbitrary_align();
    do_reset();
    align_en = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    total_cnt++;
    if (locked !== 1'b0)
      $display("FAIL junk_lock: got %b required 0", locked);
    else pass_cnt++;
    send_byte(8'hBC, 1'b0);
    total_cnt++;
    if (locked !== 1'b1)
      $display("FAIL align_lock: got %b required 1", locked);
    else pass_cnt++;
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (strobe_cnt != 2 || sb.size() != 0)
      $display("FAIL align_count: got %0d/%0d required 2/0",
               strobe_cnt, sb.size());
    else pass_cnt++;
  endtask

  task automatic test_full_frame();
    do_reset();
    align_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send_byte(8'hBC, 1'b0);
      send_frame_payload();
    end
    @(negedge clk);
    total_cnt++;
    if (strobe_cnt != 30 || sb.size() != 0)
      $display("FAIL frame_count: got %0d/%0d required 30/0",
               strobe_cnt, sb.size());
    else pass_cnt++;
    total_cnt++;
    if (gap8 != 28 || gap16 != 1 || gap_other != 0)
      $display("FAIL frame_gaps: got %0d/%0d/%0d required 28/1/0",
               gap8, gap16, gap_other);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    do_reset();
    align_en = 1'b1;
    send_byte(8'hBC, 1'b0);
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    align_en = 1'b0;
    send_bit(1'b1);
    total_cnt++;
    if (locked !== 1'b0 || data_en !== 1'b0)
      $display("FAIL abort_mid: got lk=%b en=%b required 0/0",
               locked, data_en);
    else pass_cnt++;
    total_cnt++;
    if (data_8b_out !== 8'h5A)
      $display("FAIL abort_hold: got %h required 5a", data_8b_out);
    else pass_cnt++;
    send_byte(8'h77, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (strobe_cnt != 1 || sb.size() != 0)
      $display("FAIL abort_count: got %0d/%0d required 1/0",
               strobe_cnt, sb.size());
    else pass_cnt++;

    do_reset();
    align_en = 1'b1;
    send_byte(8'hBC, 1'b0);
    send_byte(8'h5A, 1'b1);
    for (int i = 7; i >= 1; i--) send_bit(1'b1);
    align_en = 1'b0;
    send_bit(1'b1);
    total_cnt++;
    if (data_en !== 1'b0 || locked !== 1'b0)
      $display("FAIL abort_edge: got en=%b lk=%b required 0/0",
               data_en, locked);
    else pass_cnt++;
    total_cnt++;
    if (data_8b_out !== 8'h5A)
      $display("FAIL abort_edge_hold: got %h required 5a",
               data_8b_out);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (strobe_cnt != 1)
      $display("FAIL abort_edge_count: got %0d required 1",
               strobe_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_midword();
    do_reset();
    align_en = 1'b1;
    send_byte(8'hBC, 1'b0);
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (data_8b_out !== 8'h00 || data_en !== 1'b0)
      $display("FAIL rst_mid_data: got %h en=%b required 00/0",
               data_8b_out, data_en);
    else pass_cnt++;
    total_cnt++;
    if (locked !== 1'b0 || sync_err !== 1'b0)
      $display("FAIL rst_mid_flags: got lk=%b se=%b required 0/0",
               locked, sync_err);
    else pass_cnt++;
    total_cnt++;
    if (strobe_cnt != 1 || sb.size() != 0)
      $display("FAIL rst_mid_count: got %0d/%0d required 1/0",
               strobe_cnt, sb.size());
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sync_loss();
    do_reset();
    align_en = 1'b1;
    send_byte(8'hBC, 1'b0);
    send_frame_payload();
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBD, 1'b0);
      total_cnt++;
      if (sync_err !== LOSS)
        $display("FAIL loss_pulse%0d: got %b required %b",
                 k, sync_err, LOSS);
      else pass_cnt++;
      total_cnt++;
      if (locked !== ((k < 2) ? 1'b1 : !LOSS))
        $display("FAIL loss_lock%0d: got %b required %b", k,
                 locked, (k < 2) ? 1'b1 : !LOSS);
      else pass_cnt++;
      if (k < 2) send_frame_payload();
    end
    @(negedge clk);
    total_cnt++;
    if (serr_cnt != (LOSS ? 3 : 0) || sb.size() != 0)
      $display("FAIL loss_count: got %0d/%0d required %0d/0",
               serr_cnt, sb.size(), LOSS ? 3 : 0);
    else pass_cnt++;
  endtask

  task automatic test_sync_recover();
    do_reset();
    align_en = 1'b1;
    send_byte(8'hBC, 1'b0);
    send_frame_payload();
    send_byte(8'hBD, 1'b0);
    send_frame_payload();
    send_byte(8'hBD, 1'b0);
    send_frame_payload();
    send_byte(8'hBC, 1'b0);
    total_cnt++;
    if (sync_err !== 1'b0 || locked !== 1'b1)
      $display("FAIL recover_good: got se=%b lk=%b required 0/1",
               sync_err, locked);
    else pass_cnt++;
    send_frame_payload();
    send_byte(8'hBD, 1'b0);
    total_cnt++;
    if (locked !== 1'b1)
      $display("FAIL recover_lock: got %b required 1", locked);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (serr_cnt != (LOSS ? 3 : 0) || sb.size() != 0)
      $display("FAIL recover_count: got %0d/%0d required %0d/0",
               serr_cnt, sb.size(), LOSS ? 3 : 0);
    else pass_cnt++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    test_reset();
    test_lock_first_word();
    test_arbitrary_align();
    test_full_frame();
    test_abort();
    test_reset_midword();
    test_sync_loss();
    test_sync_recover();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
